// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder result checker: FSM state encoding and
// default sizing of the adder under test and the per-run vector budget.
package adder_chk_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_VEC = 256;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/adder_ref_model.sv
// Golden adder: the zero-extended (WIDTH+1)-bit sum a + b + ci that the
// adder under test is expected to produce.
module adder_ref_model
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/rca_result_checker.sv
// Response checker for the adder test flow: compares adder outputs against the
// golden sum, counts vectors and mismatches per run, and latches the first failure.
module rca_result_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [WIDTH-1:0] dut_s,
    input  logic             dut_co,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [WIDTH-1:0] ff_a,
    output logic [WIDTH-1:0] ff_b,
    output logic             ff_ci
);

    localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state;
    logic [WIDTH:0]   exp_sum;
    logic             mismatch;
    logic [CNT_W-1:0] err_next;

    adder_ref_model #(
        .WIDTH(WIDTH)
    ) u_ref (
        .a  (in_a),
        .b  (in_b),
        .ci (in_ci),
        .sum(exp_sum)
    );

    assign mismatch = ({dut_co, dut_s} != exp_sum);

    // Saturating error count including the current vector, so the final
    // pass decision can account for the last vector of the run.
    always_comb begin
        err_next = err_cnt;
        if (mismatch && (err_cnt != CNT_MAX)) begin
            err_next = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            fail_seen <= 1'b0;
            ff_a      <= '0;
            ff_b      <= '0;
            ff_ci     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        vec_cnt   <= '0;
                        err_cnt   <= '0;
                        fail_seen <= 1'b0;
                        ff_a      <= '0;
                        ff_b      <= '0;
                        ff_ci     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        vec_cnt <= vec_cnt + 1'b1;
                        err_cnt <= err_next;
                        if (mismatch) begin
                            fail_seen <= 1'b1;
                            if (!fail_seen) begin
                                ff_a  <= in_a;
                                ff_b  <= in_b;
                                ff_ci <= in_ci;
                            end
                        end
                        if (vec_cnt == LAST_VEC) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == '0);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
